// File: rtl/fft_power_serializer_if.sv
// Stream bus of the power serializer: frame capture inputs, valid/ready beat outputs,
// overflow flag and its clear.
interface fft_power_serializer_if #(
  parameter int S_WIDTH = 32,
  parameter int CHANELS = 2,
  parameter int P_WIDTH = 64,
  parameter int CH_W    = (CHANELS > 1) ? $clog2(CHANELS) : 1
);
  logic                              valid_i;
  logic [CHANELS-1:0][S_WIDTH-1:0]   re;
  logic [CHANELS-1:0][S_WIDTH-1:0]   im;
  logic                              valid_o;
  logic                              ready_i;
  logic [P_WIDTH-1:0]                power_o;
  logic [CH_W-1:0]                   ch_o;
  logic                              last_o;
  logic                              overflow_o;
  logic                              clr_ovf_i;

  modport master (
    output valid_i, re, im, ready_i, clr_ovf_i,
    input  valid_o, power_o, ch_o, last_o, overflow_o
  );
  modport slave (
    input  valid_i, re, im, ready_i, clr_ovf_i,
    output valid_o, power_o, ch_o, last_o, overflow_o
  );
endinterface

// File: rtl/fft_power_serializer.sv
// Buffers finished DFT frames (2 entries) and streams |X|^2 one channel per beat.
// Optional FFT_PWR_SAT_EN: saturate power_o instead of truncating the high bits.
module fft_power_serializer #(
  parameter int S_WIDTH = 32,
  parameter int CHANELS = 2,
  parameter int P_WIDTH = 64,
  parameter int P_SHIFT = 0,
  localparam int CH_W   = (CHANELS > 1) ? $clog2(CHANELS) : 1
) (
  input logic                  clk,
  input logic                  rstn,
  fft_power_serializer_if.slave bus
);
  localparam int SUM_W = 2*S_WIDTH + 1;
  localparam int EXT_W = (P_WIDTH > SUM_W) ? P_WIDTH : SUM_W;

  typedef enum logic {IDLE, RUN} state_t;
  state_t state_q, state_d;

  logic [1:0][CHANELS-1:0][S_WIDTH-1:0] fb_re, fb_im;
  logic [1:0]           count, count_nxt;
  logic                 wr_ptr, rd_ptr;
  logic [CH_W-1:0]      ch;
  logic                 stall, issue, last_ch, pop, push;

  // [1] = stage 1 (squares), [2] = stage 2 (output beat)
  logic [2:1]           vld_pipe;
  logic [2*S_WIDTH-1:0] re2, im2;
  logic [CH_W-1:0]      s1_ch, ch_q;
  logic                 s1_last, last_q, ovf_q;
  logic [P_WIDTH-1:0]   power_q, power_d;

  logic [S_WIDTH-1:0]   sel_re, sel_im;
  logic [2*S_WIDTH-1:0] xr, xi;
  logic [SUM_W-1:0]     sum;
  logic [EXT_W-1:0]     shx;

  assign stall   = vld_pipe[2] && !bus.ready_i;
  assign last_ch = (ch == CH_W'(CHANELS-1));

  always_comb begin
    state_d   = state_q;
    issue     = (state_q == RUN) && !stall;
    pop       = issue && last_ch;
    push      = bus.valid_i && ((count != 2'd2) || pop);
    count_nxt = count + {1'b0, push} - {1'b0, pop};
    case (state_q)
      IDLE: if (count != 2'd0) state_d = RUN;
      RUN:  if (pop && (count_nxt == 2'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Sign-extend so the low 2*S_WIDTH bits of the product are the signed square.
  assign sel_re = fb_re[rd_ptr][ch];
  assign sel_im = fb_im[rd_ptr][ch];
  assign xr     = {{S_WIDTH{sel_re[S_WIDTH-1]}}, sel_re};
  assign xi     = {{S_WIDTH{sel_im[S_WIDTH-1]}}, sel_im};
  assign sum    = {1'b0, re2} + {1'b0, im2};
  assign shx    = EXT_W'(sum) >> P_SHIFT;

`ifdef FFT_PWR_SAT_EN
  assign power_d = ((shx >> P_WIDTH) != '0) ? '1 : P_WIDTH'(shx);
`else
  assign power_d = P_WIDTH'(shx);
`endif

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q  <= IDLE;
      count    <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      ch       <= '0;
      fb_re    <= '0;
      fb_im    <= '0;
      ovf_q    <= 1'b0;
      vld_pipe <= '0;
      re2      <= '0;
      im2      <= '0;
      s1_ch    <= '0;
      s1_last  <= 1'b0;
      power_q  <= '0;
      ch_q     <= '0;
      last_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count   <= count_nxt;
      if (push) begin
        fb_re[wr_ptr] <= bus.re;
        fb_im[wr_ptr] <= bus.im;
        wr_ptr        <= ~wr_ptr;
      end
      // A drop in the same cycle as a clear keeps the flag set.
      if (bus.valid_i && !push) ovf_q <= 1'b1;
      else if (bus.clr_ovf_i)   ovf_q <= 1'b0;
      if (issue) begin
        ch <= pop ? '0 : ch + 1'b1;
        if (pop) rd_ptr <= ~rd_ptr;
      end
      if (!stall) begin
        vld_pipe[1] <= issue;
        re2         <= xr * xr;
        im2         <= xi * xi;
        s1_ch       <= ch;
        s1_last     <= last_ch;
        vld_pipe[2] <= vld_pipe[1];
        power_q     <= power_d;
        ch_q        <= s1_ch;
        last_q      <= s1_last;
      end
    end
  end

  assign bus.valid_o    = vld_pipe[2];
  assign bus.power_o    = power_q;
  assign bus.ch_o       = ch_q;
  assign bus.last_o     = last_q;
  assign bus.overflow_o = ovf_q;
endmodule

// File: tb/tb_fft_power_serializer.sv
// Directed bench for fft_power_serializer: default instance plus a 16-bit power instance.
module tb_fft_power_serializer;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  fft_power_serializer_if bus ();
  fft_power_serializer_if #(.P_WIDTH(16)) bus16 ();

  fft_power_serializer dut (.clk(clk), .rstn(rstn), .bus(bus));
  fft_power_serializer #(.P_WIDTH(16)) dut16 (.clk(clk), .rstn(rstn), .bus(bus16));

  logic [63:0] beat_pw[$];
  int          beat_ch[$];
  int          beat_cyc[$];

  task automatic tick;
    @(posedge clk); #1;
  endtask

  function automatic logic [63:0] pk(input int hi, input int lo);
    return {hi, lo};
  endfunction

  task automatic send(input logic [63:0] r, input logic [63:0] i);
    bus.re = r; bus.im = i; bus.valid_i = 1'b1;
    tick;
    bus.valid_i = 1'b0;
  endtask

  // Records every beat shown while ready_i=1 (accepted at the following edge).
  task automatic collect(input int cycles);
    beat_pw.delete(); beat_ch.delete(); beat_cyc.delete();
    for (int c = 0; c < cycles; c++) begin
      if (bus.valid_o && bus.ready_i) begin
        beat_pw.push_back(bus.power_o);
        beat_ch.push_back(int'(bus.ch_o));
        beat_cyc.push_back(c);
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rstn = 1'b0; tick; tick;
    total++;
    if ({bus.valid_o, bus.ch_o, bus.last_o, bus.overflow_o, bus.power_o} !== 68'd0) begin
      bad++; $display("FAIL reset_outputs got=%h exp=0",
        {bus.valid_o, bus.ch_o, bus.last_o, bus.overflow_o, bus.power_o});
    end
    rstn = 1'b1; tick;
  endtask

  task automatic test_single;
    bus.ready_i = 1'b1;
    send(pk(-5, 3), pk(12, 4));
    tick; tick;
    total++;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL single_early valid_o=%b exp=0", bus.valid_o); end
    tick;
    total++;
    if ({bus.valid_o, bus.ch_o, bus.last_o, bus.power_o} !== {1'b1, 1'b0, 1'b0, 64'd25}) begin
      bad++; $display("FAIL single_beat0 got=%h exp=%h", {bus.valid_o, bus.ch_o, bus.last_o, bus.power_o},
        {1'b1, 1'b0, 1'b0, 64'd25});
    end
    tick;
    total++;
    if ({bus.valid_o, bus.ch_o, bus.last_o, bus.power_o} !== {1'b1, 1'b1, 1'b1, 64'd169}) begin
      bad++; $display("FAIL single_beat1 got=%h exp=%h", {bus.valid_o, bus.ch_o, bus.last_o, bus.power_o},
        {1'b1, 1'b1, 1'b1, 64'd169});
    end
    tick;
    total++;
    if (bus.valid_o !== 1'b0) begin bad++; $display("FAIL single_drop valid_o=%b exp=0", bus.valid_o); end
  endtask

  task automatic test_backpressure;
    bus.ready_i = 1'b0;
    send(pk(-5, 3), pk(12, 4));
    tick; tick; tick;
    for (int k = 0; k < 5; k++) begin
      total++;
      if ({bus.valid_o, bus.ch_o, bus.power_o} !== {1'b1, 1'b0, 64'd25}) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%h exp=%h", k, {bus.valid_o, bus.ch_o, bus.power_o},
          {1'b1, 1'b0, 64'd25});
      end
      tick;
    end
    bus.ready_i = 1'b1;
    collect(6);
    total++;
    if (beat_pw.size() !== 2) begin
      bad++; $display("FAIL bp_count got=%0d exp=2", beat_pw.size());
    end else begin
      total++;
      if (beat_pw[0] !== 64'd25 || beat_pw[1] !== 64'd169 || beat_ch[0] !== 0 || beat_ch[1] !== 1) begin
        bad++; $display("FAIL bp_order got=%0d/%0d ch=%0d/%0d exp=25/169 ch=0/1",
          beat_pw[0], beat_pw[1], beat_ch[0], beat_ch[1]);
      end
    end
  endtask

  task automatic test_overflow;
    logic [63:0] exp_pw[4] = '{64'd4, 64'd1, 64'd36, 64'd49};
    bus.ready_i = 1'b0;
    send(pk(1, 2),   pk(0, 0));
    send(pk(0, 6),   pk(7, 0));
    send(pk(10, 10), pk(0, 0));
    total++;
    if (bus.overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_set got=%b exp=1", bus.overflow_o); end
    tick; tick; tick;
    bus.ready_i = 1'b1;
    collect(10);
    total++;
    if (beat_pw.size() !== 4) begin
      bad++; $display("FAIL ovf_count got=%0d exp=4", beat_pw.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        total++;
        if (beat_pw[k] !== exp_pw[k]) begin
          bad++; $display("FAIL ovf_beat%0d got=%0d exp=%0d", k, beat_pw[k], exp_pw[k]);
        end
      end
    end
    total++;
    if (bus.overflow_o !== 1'b1) begin bad++; $display("FAIL ovf_sticky got=%b exp=1", bus.overflow_o); end
    bus.clr_ovf_i = 1'b1; tick; bus.clr_ovf_i = 1'b0;
    total++;
    if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL ovf_clear got=%b exp=0", bus.overflow_o); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] exp_pw[6] = '{64'd4, 64'd1, 64'd36, 64'd49, 64'd100, 64'd100};
    bus.ready_i = 1'b1;
    send(pk(1, 2), pk(0, 0));
    send(pk(0, 6), pk(7, 0));
    tick;
    // Lands on the edge where frame A's last channel issues while two frames are held.
    send(pk(10, 10), pk(0, 0));
    total++;
    if (bus.overflow_o !== 1'b0) begin bad++; $display("FAIL b2b_no_ovf got=%b exp=0", bus.overflow_o); end
    collect(12);
    total++;
    if (beat_pw.size() !== 6) begin
      bad++; $display("FAIL b2b_count got=%0d exp=6", beat_pw.size());
    end else begin
      for (int k = 0; k < 6; k++) begin
        total++;
        if (beat_pw[k] !== exp_pw[k] || beat_ch[k] !== (k % 2)) begin
          bad++; $display("FAIL b2b_beat%0d got=%0d ch=%0d exp=%0d ch=%0d", k, beat_pw[k], beat_ch[k],
            exp_pw[k], k % 2);
        end
      end
      total++;
      if (beat_cyc[5] - beat_cyc[0] !== 5) begin
        bad++; $display("FAIL b2b_bubble span=%0d exp=5", beat_cyc[5] - beat_cyc[0]);
      end
    end
  endtask

  task automatic test_width;
    logic [15:0] exp16;
`ifdef FFT_PWR_SAT_EN
    exp16 = 16'd65535;
`else
    exp16 = 16'd24464;
`endif
    bus16.re = pk(0, 300); bus16.im = '0; bus16.valid_i = 1'b1;
    tick;
    bus16.valid_i = 1'b0;
    tick; tick; tick;
    total++;
    if ({bus16.valid_o, bus16.ch_o, bus16.power_o} !== {1'b1, 1'b0, exp16}) begin
      bad++; $display("FAIL width_ch0 got=%h exp=%h", {bus16.valid_o, bus16.ch_o, bus16.power_o},
        {1'b1, 1'b0, exp16});
    end
    tick;
    total++;
    if ({bus16.valid_o, bus16.ch_o, bus16.power_o} !== {1'b1, 1'b1, 16'd0}) begin
      bad++; $display("FAIL width_ch1 got=%h exp=%h", {bus16.valid_o, bus16.ch_o, bus16.power_o},
        {1'b1, 1'b1, 16'd0});
    end
    tick; tick;
  endtask

  task automatic test_reset_mid;
    bit seen = 1'b0;
    bus.ready_i = 1'b1;
    send(pk(-5, 3), pk(12, 4));
    send(pk(1, 2), pk(0, 0));
    tick; tick;
    total++;
    if ({bus.valid_o, bus.ch_o} !== 2'b10) begin
      bad++; $display("FAIL rstmid_pre got=%b exp=10", {bus.valid_o, bus.ch_o});
    end
    rstn = 1'b0; tick; rstn = 1'b1;
    total++;
    if ({bus.valid_o, bus.ch_o, bus.last_o, bus.overflow_o, bus.power_o} !== 68'd0) begin
      bad++; $display("FAIL rstmid_outputs got=%h exp=0",
        {bus.valid_o, bus.ch_o, bus.last_o, bus.overflow_o, bus.power_o});
    end
    for (int k = 0; k < 8; k++) begin
      if (bus.valid_o) seen = 1'b1;
      tick;
    end
    total++;
    if (seen !== 1'b0) begin bad++; $display("FAIL rstmid_silent valid_seen=%b exp=0", seen); end
    send(pk(1, 2), pk(0, 0));
    tick; tick; tick;
    total++;
    if ({bus.valid_o, bus.ch_o, bus.power_o} !== {1'b1, 1'b0, 64'd4}) begin
      bad++; $display("FAIL rstmid_restart got=%h exp=%h", {bus.valid_o, bus.ch_o, bus.power_o},
        {1'b1, 1'b0, 64'd4});
    end
    tick; tick;
  endtask

  initial begin
    bus.valid_i = 1'b0; bus.re = '0; bus.im = '0; bus.ready_i = 1'b1; bus.clr_ovf_i = 1'b0;
    bus16.valid_i = 1'b0; bus16.re = '0; bus16.im = '0; bus16.ready_i = 1'b1; bus16.clr_ovf_i = 1'b0;
    test_reset;
    test_single;
    test_backpressure;
    test_overflow;
    test_back_to_back;
    test_width;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
